// File: rtl/wb_arb_pkg.sv
// ============================================================================
// wb_arb_pkg : shared types/constants for the write-back port arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package wb_arb_pkg;

    localparam int             REG_IDX_W = 4;
    localparam int             NUM_REGS  = 15;
    localparam logic [3:0]     PC_IDX    = 4'd15;
    localparam int             DATA_W    = 32;

    typedef struct packed {
        logic [REG_IDX_W-1:0] dest;
        logic [DATA_W-1:0]    value;
    } wb_entry_t;

    // One-hot over tracked registers only; the PC index maps to all-zero.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            r[i] = (idx == REG_IDX_W'(i));
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
// ============================================================================
// wb_port_arbiter_if : pipeline/long-latency/ID/register-file side signals
// Rev 1.0
// ============================================================================
`default_nettype none

interface wb_port_arbiter_if;
    import wb_arb_pkg::*;

    logic                 pipe_wb_en;
    logic [REG_IDX_W-1:0] pipe_wb_dest;
    logic [DATA_W-1:0]    pipe_wb_value;

    logic                 mc_valid;
    logic [REG_IDX_W-1:0] mc_dest;
    logic [DATA_W-1:0]    mc_value;
    logic                 mc_ready;

    logic                 issue_en;
    logic [REG_IDX_W-1:0] issue_dest;

    logic [REG_IDX_W-1:0] chk_src1;
    logic [REG_IDX_W-1:0] chk_src2;
    logic [REG_IDX_W-1:0] chk_dest;
    logic                 chk_src1_used;
    logic                 chk_src2_used;
    logic                 chk_dest_used;

    logic                 hazard;
    logic [NUM_REGS-1:0]  pending;
    logic                 stall_req;

    logic                 rf_wb_en;
    logic [REG_IDX_W-1:0] rf_dest;
    logic [DATA_W-1:0]    rf_value;
    logic                 err;

    modport master (
        output pipe_wb_en, pipe_wb_dest, pipe_wb_value,
        output mc_valid, mc_dest, mc_value,
        input  mc_ready,
        output issue_en, issue_dest,
        output chk_src1, chk_src2, chk_dest,
        output chk_src1_used, chk_src2_used, chk_dest_used,
        input  hazard, pending, stall_req,
        input  rf_wb_en, rf_dest, rf_value, err
    );

    modport slave (
        input  pipe_wb_en, pipe_wb_dest, pipe_wb_value,
        input  mc_valid, mc_dest, mc_value,
        output mc_ready,
        input  issue_en, issue_dest,
        input  chk_src1, chk_src2, chk_dest,
        input  chk_src1_used, chk_src2_used, chk_dest_used,
        output hazard, pending, stall_req,
        output rf_wb_en, rf_dest, rf_value, err
    );

endinterface

`default_nettype wire

// File: rtl/wb_result_fifo.sv
// ============================================================================
// wb_result_fifo : small FIFO of long-latency results awaiting the WB port
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_result_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      push,
    input  wire wb_entry_t                 push_data,
    input  wire logic                      pop,
    output wb_entry_t                      head,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH):0]         count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t         mem_q [DEPTH];
    wb_entry_t         mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              w_do_push;
    logic              w_do_pop;

    // A full FIFO refuses pushes even when popping: no pop-through.
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// wb_port_arbiter : shares the register-file write port between the pipeline
// WB stage and a buffered long-latency unit; tracks pending destinations.
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic    clk,
    input  wire logic    rst,
    wb_port_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    wb_entry_t            w_head;
    wb_entry_t            w_push_data;
    logic                 w_full;
    logic                 w_empty;
    logic [CNT_W-1:0]     w_count;
    logic                 w_push;
    logic                 w_pop;

    logic [AGE_W-1:0]     age_q, age_d;
    logic                 stall_q, stall_d;
    logic [NUM_REGS-1:0]  pending_q, pending_d;
    logic                 err_q, err_d;

    logic [NUM_REGS-1:0]  w_set_vec;
    logic [NUM_REGS-1:0]  w_clr_vec;
    logic [NUM_REGS:0]    w_pend_ext;
    logic                 w_err_stall;
    logic                 w_err_reissue;
    logic                 w_err_orphan;

    assign w_push_data = '{dest: bus.mc_dest, value: bus.mc_value};
    assign w_push      = bus.mc_valid & ~w_full;
    assign w_pop       = ~bus.pipe_wb_en & ~w_empty;
    assign bus.mc_ready = (w_count < CNT_W'(DEPTH));

    wb_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // The pipeline always wins; the FIFO head only uses idle slots.
    always_comb begin
        bus.rf_wb_en = 1'b0;
        bus.rf_dest  = '0;
        bus.rf_value = '0;
        if (bus.pipe_wb_en) begin
            bus.rf_wb_en = 1'b1;
            bus.rf_dest  = bus.pipe_wb_dest;
            bus.rf_value = bus.pipe_wb_value;
        end else if (!w_empty) begin
            bus.rf_wb_en = 1'b1;
            bus.rf_dest  = w_head.dest;
            bus.rf_value = w_head.value;
        end
    end

    always_comb begin
        age_d = age_q;
        if (w_empty || w_pop) begin
            age_d = '0;
        end else if (age_q < AGE_W'(STARVE_LIMIT)) begin
            age_d = age_q + AGE_W'(1);
        end
        stall_d = (age_d >= AGE_W'(STARVE_LIMIT));
    end

    // Extra always-zero top bit lets index 15 read as "not pending".
    assign w_pend_ext = {1'b0, pending_q};
    assign w_set_vec  = bus.issue_en ? reg_onehot(bus.issue_dest) : '0;
    assign w_clr_vec  = w_pop ? reg_onehot(w_head.dest) : '0;

    always_comb begin
        pending_d = (pending_q & ~w_clr_vec) | w_set_vec;
    end

    assign w_err_stall   = bus.pipe_wb_en & stall_q;
    assign w_err_reissue = |(w_set_vec & pending_q & ~w_clr_vec);
    assign w_err_orphan  = w_push & (bus.mc_dest != PC_IDX) & ~w_pend_ext[bus.mc_dest];

    always_comb begin
        err_d = err_q | w_err_stall | w_err_reissue | w_err_orphan;
    end

    assign bus.hazard = (bus.chk_src1_used & w_pend_ext[bus.chk_src1])
                      | (bus.chk_src2_used & w_pend_ext[bus.chk_src2])
                      | (bus.chk_dest_used & w_pend_ext[bus.chk_dest]);

    assign bus.pending   = pending_q;
    assign bus.stall_req = stall_q;
    assign bus.err       = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age_q     <= '0;
            stall_q   <= 1'b0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            age_q     <= age_d;
            stall_q   <= stall_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

endmodule

`default_nettype wire
